// File: rtl/stream_packer_n.sv
// Packs SIZE consecutive WIDTH-bit beats into one SIZE*WIDTH word, first beat in slot 0.
// Word is valid the cycle after its completing beat; under backpressure only the completing beat stalls.
module stream_packer_n #(
    parameter int SIZE  = 8,
    parameter int WIDTH = 32
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iValid_AM,
    output logic                  oReady_AM,
    input  logic [WIDTH-1:0]      iData_AM,
    output logic                  oValid_BM,
    input  logic                  iReady_BM,
    output logic [SIZE*WIDTH-1:0] oData_BM
);
    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    logic [CW-1:0]         cnt;
    logic [SIZE*WIDTH-1:0] acc;
    logic [SIZE*WIDTH-1:0] wordNext;
    logic                  lastSlot;
    logic                  inXfer;
    logic                  outXfer;
    logic                  complete;

    assign lastSlot  = (cnt == LAST);
    // Partial beats always land in acc; only the completing beat needs the output register free.
    assign oReady_AM = !lastSlot || !oValid_BM || iReady_BM;
    assign inXfer    = iValid_AM && oReady_AM;
    assign outXfer   = oValid_BM && iReady_BM;
    assign complete  = inXfer && lastSlot;

    always_comb begin
        wordNext = acc;
        wordNext[(SIZE-1)*WIDTH +: WIDTH] = iData_AM;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            cnt <= '0;
            acc <= '0;
        end else if (inXfer) begin
            if (lastSlot) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            for (int k = 0; k < SIZE - 1; k++) begin
                if (!lastSlot && cnt == CW'(k)) begin
                    acc[k*WIDTH +: WIDTH] <= iData_AM;
                end
            end
        end
    end

    // A completing beat in the same cycle as an output transfer refills without a bubble.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oValid_BM <= 1'b0;
            oData_BM  <= '0;
        end else if (complete) begin
            oValid_BM <= 1'b1;
            oData_BM  <= wordNext;
        end else if (outXfer) begin
            oValid_BM <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stream_packer_n.sv
// Directed vector table on a 4x8 packer, reset/backpressure sequences, then randomised
// scoreboards on a 1x16 and an 8x32 packer.
module tb_stream_packer_n;
    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    // 4 x 8-bit instance
    logic        aV, aRdyO, aOV, aR;
    logic [7:0]  aD;
    logic [31:0] aOD;
    // 1 x 16-bit instance
    logic        bV, bRdyO, bOV, bR;
    logic [15:0] bD, bOD;
    // 8 x 32-bit instance
    logic         cV, cRdyO, cOV, cR;
    logic [31:0]  cD;
    logic [255:0] cOD;

    stream_packer_n #(.SIZE(4), .WIDTH(8)) uA (
        .iCLK(clk), .iRST(rstN), .iValid_AM(aV), .oReady_AM(aRdyO), .iData_AM(aD),
        .oValid_BM(aOV), .iReady_BM(aR), .oData_BM(aOD));
    stream_packer_n #(.SIZE(1), .WIDTH(16)) uB (
        .iCLK(clk), .iRST(rstN), .iValid_AM(bV), .oReady_AM(bRdyO), .iData_AM(bD),
        .oValid_BM(bOV), .iReady_BM(bR), .oData_BM(bOD));
    stream_packer_n #(.SIZE(8), .WIDTH(32)) uC (
        .iCLK(clk), .iRST(rstN), .iValid_AM(cV), .oReady_AM(cRdyO), .iData_AM(cD),
        .oValid_BM(cOV), .iReady_BM(cR), .oData_BM(cOD));

    int nVec = 0;
    int nErr = 0;

    typedef struct {
        logic        vld;
        logic [7:0]  dat;
        logic        rdy;
        logic        expV;
        logic        chkD;
        logic [31:0] expD;
        logic        expR;
    } vec_t;

    vec_t vecs[$];

    function automatic void addv(input logic vld, input logic [7:0] dat, input logic rdy,
                                 input logic ev, input logic cd, input logic [31:0] ed,
                                 input logic er);
        vec_t v;
        v.vld = vld; v.dat = dat; v.rdy = rdy;
        v.expV = ev; v.chkD = cd; v.expD = ed; v.expR = er;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the edge, check outputs at the following negedge.
    task automatic applyVec(input vec_t v, input string tag);
        @(posedge clk); #1;
        aV = v.vld; aD = v.dat; aR = v.rdy;
        @(negedge clk);
        chk({tag, ".valid"}, {255'd0, aOV}, {255'd0, v.expV});
        chk({tag, ".ready"}, {255'd0, aRdyO}, {255'd0, v.expR});
        if (v.chkD) chk({tag, ".data"}, {224'd0, aOD}, {224'd0, v.expD});
    endtask

    task automatic hand(input logic vld, input logic [7:0] dat, input logic rdy,
                        input logic ev, input logic cd, input logic [31:0] ed,
                        input logic er, input string tag);
        vec_t v;
        v.vld = vld; v.dat = dat; v.rdy = rdy;
        v.expV = ev; v.chkD = cd; v.expD = ed; v.expR = er;
        applyVec(v, tag);
    endtask

    task automatic runB();
        logic [15:0] q[$];
        logic        hold = 1'b0;
        logic        stall = 1'b0;
        logic [15:0] prevD = '0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk); #1;
            if (!hold) begin
                bV = ($urandom_range(0, 3) != 0);
                bD = 16'($urandom);
            end
            bR = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (stall) begin
                chk("B.hold_valid", {255'd0, bOV}, {255'd0, 1'b1});
                chk("B.hold_data", {240'd0, bOD}, {240'd0, prevD});
            end
            chk("B.ready", {255'd0, bRdyO}, {255'd0, (!bOV || bR)});
            if (bOV && bR) begin
                if (q.size() == 0) chk("B.unexpected_word", {240'd0, bOD}, 256'd0 - 1);
                else chk("B.word", {240'd0, bOD}, {240'd0, q.pop_front()});
            end
            if (bV && bRdyO) q.push_back(bD);
            hold  = bV && !bRdyO;
            stall = bOV && !bR;
            prevD = bOD;
        end
        @(posedge clk); #1;
        bV = 1'b0;
    endtask

    task automatic runC();
        logic [31:0]  q[$];
        logic         hold = 1'b0;
        logic         stall = 1'b0;
        logic [255:0] prevD = '0;
        logic [255:0] exp;
        int           beatsIn = 0;
        int           wordsOut = 0;
        int           cyc = 0;
        while (wordsOut < 1250 && cyc < 40000) begin
            cyc++;
            @(posedge clk); #1;
            if (!hold) begin
                cV = (beatsIn < 10000) && ($urandom_range(0, 3) != 0);
                cD = $urandom;
            end
            cR = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (stall) begin
                chk("C.hold_valid", {255'd0, cOV}, {255'd0, 1'b1});
                chk("C.hold_data", cOD, prevD);
            end
            if (cOV && cR) begin
                if (q.size() < 8) begin
                    chk("C.short_queue", 256'(q.size()), 256'd8);
                end else begin
                    exp = '0;
                    for (int k = 0; k < 8; k++) exp[k*32 +: 32] = q.pop_front();
                    chk("C.word", cOD, exp);
                end
                wordsOut++;
            end
            if (cV && cRdyO) begin
                q.push_back(cD);
                beatsIn++;
            end
            hold  = cV && !cRdyO;
            stall = cOV && !cR;
            prevD = cOD;
        end
        chk("C.words_out", 256'(wordsOut), 256'd1250);
        @(posedge clk); #1;
        cV = 1'b0;
    endtask

    logic [31:0] words[4];

    initial begin
        rstN = 1'b0;
        aV = 0; aD = '0; aR = 0;
        bV = 0; bD = '0; bR = 0;
        cV = 0; cD = '0; cR = 0;
        words[0] = 32'h03020100; words[1] = 32'h07060504;
        words[2] = 32'h0B0A0908; words[3] = 32'h0F0E0D0C;

        // Single word 11,22,33,44, then a continuous 00..0F stream.
        addv(1, 8'h11, 1, 0, 1, 32'h0, 1);
        addv(1, 8'h22, 1, 0, 1, 32'h0, 1);
        addv(1, 8'h33, 1, 0, 1, 32'h0, 1);
        addv(1, 8'h44, 1, 0, 1, 32'h0, 1);
        addv(0, 8'h00, 1, 1, 1, 32'h44332211, 1);
        addv(0, 8'h00, 1, 0, 0, 32'h0, 1);
        for (int i = 0; i < 16; i++) begin
            logic ev;
            ev = (i % 4 == 0) && (i > 0);
            addv(1, 8'(i), 1, ev, ev, ev ? words[i/4 - 1] : 32'h0, 1);
        end
        addv(0, 8'h00, 1, 1, 1, words[3], 1);
        addv(0, 8'h00, 1, 0, 0, 32'h0, 1);
        // Backpressure: word A waits while B fills, B's last beat stalls until ready rises.
        addv(1, 8'hA0, 0, 0, 0, 32'h0, 1);
        addv(1, 8'hA1, 0, 0, 0, 32'h0, 1);
        addv(1, 8'hA2, 0, 0, 0, 32'h0, 1);
        addv(1, 8'hA3, 0, 0, 0, 32'h0, 1);
        addv(1, 8'hB0, 0, 1, 1, 32'hA3A2A1A0, 1);
        addv(1, 8'hB1, 0, 1, 1, 32'hA3A2A1A0, 1);
        addv(1, 8'hB2, 0, 1, 1, 32'hA3A2A1A0, 1);
        addv(1, 8'hB3, 0, 1, 1, 32'hA3A2A1A0, 0);
        addv(1, 8'hB3, 0, 1, 1, 32'hA3A2A1A0, 0);
        addv(1, 8'hB3, 1, 1, 1, 32'hA3A2A1A0, 1);
        addv(0, 8'h00, 1, 1, 1, 32'hB3B2B1B0, 1);
        addv(0, 8'h00, 1, 0, 0, 32'h0, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.valid", {255'd0, aOV}, 256'd0);
        chk("reset.data", {224'd0, aOD}, 256'd0);
        chk("reset.ready", {255'd0, aRdyO}, 256'd1);
        chk("reset.valid_s1", {255'd0, bOV}, 256'd0);
        chk("reset.valid_s8", {255'd0, cOV}, 256'd0);
        #2 rstN = 1'b1;

        for (int i = 0; i < vecs.size(); i++) applyVec(vecs[i], $sformatf("vec%0d", i));

        // Pending word D plus two beats of E, then asynchronous reset mid-cycle.
        hand(1, 8'hD0, 0, 0, 0, 32'h0, 1, "rst.d0");
        hand(1, 8'hD1, 0, 0, 0, 32'h0, 1, "rst.d1");
        hand(1, 8'hD2, 0, 0, 0, 32'h0, 1, "rst.d2");
        hand(1, 8'hD3, 0, 0, 0, 32'h0, 1, "rst.d3");
        hand(1, 8'hE0, 0, 1, 1, 32'hD3D2D1D0, 1, "rst.e0");
        hand(1, 8'hE1, 0, 1, 1, 32'hD3D2D1D0, 1, "rst.e1");
        @(posedge clk); #3;
        aV = 1'b0; aR = 1'b1;
        rstN = 1'b0;
        #1;
        chk("rst.async_valid", {255'd0, aOV}, 256'd0);
        chk("rst.async_data", {224'd0, aOD}, 256'd0);
        chk("rst.async_ready", {255'd0, aRdyO}, 256'd1);
        @(negedge clk); #2;
        rstN = 1'b1;
        hand(1, 8'hF0, 1, 0, 1, 32'h0, 1, "rst.f0");
        hand(1, 8'hF1, 1, 0, 1, 32'h0, 1, "rst.f1");
        hand(1, 8'hF2, 1, 0, 1, 32'h0, 1, "rst.f2");
        hand(1, 8'hF3, 1, 0, 1, 32'h0, 1, "rst.f3");
        hand(0, 8'h00, 1, 1, 1, 32'hF3F2F1F0, 1, "rst.fword");
        hand(0, 8'h00, 1, 0, 0, 32'h0, 1, "rst.idle");

        fork
            runB();
            runC();
        join

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
